csr_reg: RTL and testbench
==========================

// Module: csr_reg
// PURPOSE
// - Machine-mode CSR file for the RV32 pipeline; sits after the memory-access stage and is written from write-back.
// - Holds mstatus/mie/mip/mtvec/mscratch/mepc/mcause/mcycle/minstret; commits trap and mret state from the memory-stage exception word.
// - Supplies one combinational read port for EX and the live trap CSRs for memory-stage forwarding and trap-vector selection.
// PARAMETERS
// - MTVEC_RESET  32'h0000_0000  mtvec value after reset (bits[1:0] always 0)
// - MISA_VALUE   32'h4000_0100  constant misa readback (RV32I)
// PORTS
// - clk                     in   1   single clock; all state updates on rising edge
// - rst                     in   1   synchronous, active-high reset (`RstEnable = 1'b1)
// - we_i                    in   1   WB CSR write enable
// - waddr_i                 in   12  WB CSR write address
// - wdata_i                 in   32  WB CSR write data
// - raddr_i                 in   12  EX CSR read address
// - rdata_o                 out  32  read data, combinational, WB-write bypassed
// - excepttype_i            in   32  {Interrupt, code[30:0]} from memory stage; 0 = none
// - current_inst_address_i  in   32  PC of the memory-stage instruction
// - instret_i               in   1   one instruction retired this cycle
// - timer_int_i             in   1   level timer interrupt request
// - mstatus_o/mepc_o/mie_o/mip_o/mtvec_o/mcause_o  out  32 each  registered CSR values
// - int_pending_o           out  1   mstatus.MIE & mie[7] & mip[7]
// BEHAVIOUR
// - Reset (sync): mstatus=32'h0000_1800, mie=0, mip=0, mscratch=0, mepc=0, mcause=0, mtvec=MTVEC_RESET, mcycle=0, minstret=0; int_pending_o=0.
// - Address map: 300 mstatus, 301 misa(RO), 304 mie, 305 mtvec, 340 mscratch, 341 mepc, 342 mcause, 344 mip, B00/B80 mcycle lo/hi, B02/B82 minstret lo/hi.
// - Unmapped read -> 0; unmapped or RO write -> ignored, no error.
// - Field masks: mstatus keeps only MIE[3], MPIE[7]; MPP[12:11] hardwired 2'b11, others 0.
// - Field masks: mie keeps only bit 7; mtvec and mepc force bits[1:0]=0.
// - mip[7] <= timer_int_i every cycle (1-cycle latency); software writes to mip ignored.
// - Write latency: WB write visible on *_o next cycle; rdata_o bypasses same cycle when we_i && waddr_i==raddr_i.
// - Trap commit, excepttype_i!=0 and code!=0xa:
//   mepc<=current_inst_address_i; mcause<=excepttype_i; MPIE<=MIE; MIE<=0.
// - mret commit, code==0xa, Interrupt=0: MIE<=MPIE; MPIE<=1; mepc/mcause unchanged.
// - Priority per CSR in one cycle: trap/mret update > WB write > hardware increment.
// - Counters: mcycle +1 every cycle; minstret +1 when instret_i; both 64-bit, wrap to 0 at all-ones.
// - Counter write: writing lo or hi half replaces that half only; that cycle's increment is dropped.
// - Simultaneous trap and WB write to another CSR: both commit.
// - Reset mid-operation: sync reset overrides traps, writes and increments in the same edge.
// STRUCTURE
// - Shared package/defines: CSR address constants (CSR_REG_*), mstatus bit positions, excepttype codes 0x2/0xa/0xb.
// - Shared package/defines: MSTATUS_RESET value and field masks.
// - One sub-module csr_counter64 (64-bit counter with inc, per-half write, wrap); instantiated for mcycle and minstret.
// - Read mux and bypass are combinational inside csr_reg.
// TESTING
// - Reset: assert rst 2 cycles -> mstatus_o=32'h1800, mtvec_o=MTVEC_RESET, rdata_o(0x301)=32'h4000_0100, others 0.
// - Write/bypass: we_i=1, waddr_i=raddr_i=0x305, wdata_i=32'h8000_0103 -> rdata_o=32'h8000_0100 same cycle; mtvec_o same next cycle.
// - ecall trap: mstatus.MIE=1, excepttype_i=32'h0000_000b, PC=32'h0000_0040 -> next cycle:
//   mepc_o=0x40, mcause_o=0xb, mstatus_o=32'h1880.
// - mret: from mstatus=32'h1880, excepttype_i=32'h0000_000a -> mstatus_o=32'h1888, mepc_o unchanged.
// - Conflict: trap and WB write of 0x341 same cycle -> mepc_o=trap PC, WB data lost.
// - Counters: write mcycle lo=32'hFFFF_FFFF, hi=0, then idle 1 cycle -> mcycle hi=1, lo=0.
// - Interrupt: mie=0x80, MIE=1, timer_int_i=1 -> mip_o=0x80 after 1 cycle and int_pending_o=1.
// - Reset mid-operation: rst with we_i=1 and a trap in the same edge -> all CSRs at reset values.

Source files
------------

// File: rtl/csr_reg_pkg.sv
// Shared CSR addresses, mstatus field positions, reset values/masks and the
// memory-stage exception-word decode used by the machine-mode CSR file.
package csr_reg_pkg;

    localparam int unsigned CSR_ADDR_W = 12;

    localparam logic [11:0] CSR_REG_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_REG_MISA      = 12'h301;
    localparam logic [11:0] CSR_REG_MIE       = 12'h304;
    localparam logic [11:0] CSR_REG_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_REG_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_REG_MEPC      = 12'h341;
    localparam logic [11:0] CSR_REG_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_REG_MIP       = 12'h344;
    localparam logic [11:0] CSR_REG_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_REG_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_REG_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_REG_MINSTRETH = 12'hB82;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;
    localparam int unsigned MIP_MTIP_BIT     = 7;

    localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;
    localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
    localparam logic [31:0] MIE_WMASK     = 32'h0000_0080;
    localparam logic [31:0] ALIGN_MASK    = 32'hFFFF_FFFC;

    localparam logic [30:0] EXC_ILLEGAL = 31'h2;
    localparam logic [30:0] EXC_MRET    = 31'ha;
    localparam logic [30:0] EXC_ECALL   = 31'hb;

    typedef enum logic [1:0] {
        ExcNone,
        ExcTrap,
        ExcMret
    } exc_kind_e;

    // An interrupt-flagged word carrying the mret code commits nothing.
    function automatic exc_kind_e exc_decode(input logic [31:0] et);
        exc_kind_e kind;
        kind = ExcNone;
        if (et != 32'd0) begin
            if (et[30:0] != EXC_MRET) begin
                kind = ExcTrap;
            end else if (!et[31]) begin
                kind = ExcMret;
            end
        end
        return kind;
    endfunction

endpackage

// File: rtl/csr_reg_if.sv
// Write-back CSR write port and execute-stage CSR read port, grouped as one bus.
interface csr_reg_if;
    import csr_reg_pkg::*;

    logic                  we_i;
    logic [CSR_ADDR_W-1:0] waddr_i;
    logic [31:0]           wdata_i;
    logic [CSR_ADDR_W-1:0] raddr_i;
    logic [31:0]           rdata_o;

    modport master (
        output we_i,
        output waddr_i,
        output wdata_i,
        output raddr_i,
        input  rdata_o
    );

    modport slave (
        input  we_i,
        input  waddr_i,
        input  wdata_i,
        input  raddr_i,
        output rdata_o
    );

endinterface

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent half-word writes; a write in a
// cycle suppresses that cycle's increment. Wraps from all-ones to zero.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    input  logic        we_lo_i,
    input  logic        we_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] value_o
);

    logic [63:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (we_lo_i) begin
            cnt_d[31:0] = wdata_i;
        end
        if (we_hi_i) begin
            cnt_d[63:32] = wdata_i;
        end
        if (!we_lo_i && !we_hi_i && inc_i) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o = cnt_q;

endmodule

// File: rtl/csr_reg.sv
// Machine-mode CSR file: WB writes, trap/mret commit from the memory stage,
// cycle/instret counters and a combinational, write-bypassed EX read port.
module csr_reg
    import csr_reg_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        rst,
    csr_reg_if.slave    bus,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_address_i,
    input  logic        instret_i,
    input  logic        timer_int_i,
    output logic [31:0] mstatus_o,
    output logic [31:0] mepc_o,
    output logic [31:0] mie_o,
    output logic [31:0] mip_o,
    output logic [31:0] mtvec_o,
    output logic [31:0] mcause_o,
    output logic        int_pending_o
);

    logic [31:0] mstatus_q, mstatus_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mip_q, mip_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [63:0] mcycle, minstret;

    exc_kind_e   exc_kind;
    logic [31:0] wr_val;
    logic        wr_mapped;
    logic [31:0] rd_val;

    assign exc_kind = exc_decode(excepttype_i);

    // Masked value a WB write would commit; also what the read bypass returns.
    always_comb begin
        wr_val    = bus.wdata_i;
        wr_mapped = 1'b1;
        case (bus.waddr_i)
            CSR_REG_MSTATUS:              wr_val = MSTATUS_RESET | (bus.wdata_i & MSTATUS_WMASK);
            CSR_REG_MIE:                  wr_val = bus.wdata_i & MIE_WMASK;
            CSR_REG_MTVEC, CSR_REG_MEPC:  wr_val = bus.wdata_i & ALIGN_MASK;
            CSR_REG_MSCRATCH, CSR_REG_MCAUSE,
            CSR_REG_MCYCLE, CSR_REG_MCYCLEH,
            CSR_REG_MINSTRET, CSR_REG_MINSTRETH: wr_val = bus.wdata_i;
            default:                      wr_mapped = 1'b0;
        endcase
    end

    function automatic logic wr_hit(input logic [11:0] addr);
        return bus.we_i && (bus.waddr_i == addr);
    endfunction

    always_comb begin
        mstatus_d  = mstatus_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mie_d      = wr_hit(CSR_REG_MIE) ? wr_val : mie_q;
        mtvec_d    = wr_hit(CSR_REG_MTVEC) ? wr_val : mtvec_q;
        mscratch_d = wr_hit(CSR_REG_MSCRATCH) ? wr_val : mscratch_q;
        mip_d      = '0;
        mip_d[MIP_MTIP_BIT] = timer_int_i;

        unique case (exc_kind)
            ExcTrap: begin
                mstatus_d[MSTATUS_MPIE_BIT] = mstatus_q[MSTATUS_MIE_BIT];
                mstatus_d[MSTATUS_MIE_BIT]  = 1'b0;
                mepc_d   = current_inst_address_i & ALIGN_MASK;
                mcause_d = excepttype_i;
            end
            ExcMret: begin
                mstatus_d[MSTATUS_MIE_BIT]  = mstatus_q[MSTATUS_MPIE_BIT];
                mstatus_d[MSTATUS_MPIE_BIT] = 1'b1;
                if (wr_hit(CSR_REG_MEPC)) mepc_d = wr_val;
                if (wr_hit(CSR_REG_MCAUSE)) mcause_d = wr_val;
            end
            default: begin
                if (wr_hit(CSR_REG_MSTATUS)) mstatus_d = wr_val;
                if (wr_hit(CSR_REG_MEPC)) mepc_d = wr_val;
                if (wr_hit(CSR_REG_MCAUSE)) mcause_d = wr_val;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_q  <= MSTATUS_RESET;
            mie_q      <= '0;
            mip_q      <= '0;
            mtvec_q    <= MTVEC_RESET & ALIGN_MASK;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            mstatus_q  <= mstatus_d;
            mie_q      <= mie_d;
            mip_q      <= mip_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

    csr_counter64 u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (1'b1),
        .we_lo_i (wr_hit(CSR_REG_MCYCLE)),
        .we_hi_i (wr_hit(CSR_REG_MCYCLEH)),
        .wdata_i (bus.wdata_i),
        .value_o (mcycle)
    );

    csr_counter64 u_minstret (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (instret_i),
        .we_lo_i (wr_hit(CSR_REG_MINSTRET)),
        .we_hi_i (wr_hit(CSR_REG_MINSTRETH)),
        .wdata_i (bus.wdata_i),
        .value_o (minstret)
    );

    always_comb begin
        rd_val = '0;
        case (bus.raddr_i)
            CSR_REG_MSTATUS:   rd_val = mstatus_q;
            CSR_REG_MISA:      rd_val = MISA_VALUE;
            CSR_REG_MIE:       rd_val = mie_q;
            CSR_REG_MTVEC:     rd_val = mtvec_q;
            CSR_REG_MSCRATCH:  rd_val = mscratch_q;
            CSR_REG_MEPC:      rd_val = mepc_q;
            CSR_REG_MCAUSE:    rd_val = mcause_q;
            CSR_REG_MIP:       rd_val = mip_q;
            CSR_REG_MCYCLE:    rd_val = mcycle[31:0];
            CSR_REG_MCYCLEH:   rd_val = mcycle[63:32];
            CSR_REG_MINSTRET:  rd_val = minstret[31:0];
            CSR_REG_MINSTRETH: rd_val = minstret[63:32];
            default:           rd_val = '0;
        endcase
    end

    assign bus.rdata_o = (bus.we_i && wr_mapped && (bus.waddr_i == bus.raddr_i)) ? wr_val : rd_val;

    assign mstatus_o     = mstatus_q;
    assign mepc_o        = mepc_q;
    assign mie_o         = mie_q;
    assign mip_o         = mip_q;
    assign mtvec_o       = mtvec_q;
    assign mcause_o      = mcause_q;
    assign int_pending_o = mstatus_q[MSTATUS_MIE_BIT] & mie_q[7] & mip_q[MIP_MTIP_BIT];

endmodule

// File: tb/tb_csr_reg.sv
// Randomized bench for csr_reg against a field-level behavioural model, plus
// directed scenarios with hand-computed expectations.
module tb_csr_reg;
    import csr_reg_pkg::*;

    localparam logic [31:0] TB_MTVEC_RESET = 32'h0000_1003;
    localparam logic [31:0] TB_MISA        = 32'h4000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] excepttype, pc;
    logic        instret, timer;
    logic [31:0] mstatus_o, mepc_o, mie_o, mip_o, mtvec_o, mcause_o;
    logic        int_pending;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    csr_reg_if bus ();

    csr_reg #(
        .MTVEC_RESET (TB_MTVEC_RESET),
        .MISA_VALUE  (TB_MISA)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .bus                    (bus),
        .excepttype_i           (excepttype),
        .current_inst_address_i (pc),
        .instret_i              (instret),
        .timer_int_i            (timer),
        .mstatus_o              (mstatus_o),
        .mepc_o                 (mepc_o),
        .mie_o                  (mie_o),
        .mip_o                  (mip_o),
        .mtvec_o                (mtvec_o),
        .mcause_o               (mcause_o),
        .int_pending_o          (int_pending)
    );

    always #5 clk = ~clk;

    // Model state: architectural fields, not register images.
    bit          m_mie, m_mpie;
    logic [31:0] m_mie_reg, m_mip, m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_cyc, m_ret;

    function automatic logic [31:0] m_mstatus();
        return 32'h1800 + (m_mpie ? 32'h80 : 32'h0) + (m_mie ? 32'h8 : 32'h0);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus();
            12'h301: return 32'h4000_0100;
            12'h304: return m_mie_reg;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_mip;
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_ret[31:0];
            12'hB82: return m_ret[63:32];
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_writable(input logic [11:0] a);
        return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                         12'hB00, 12'hB80, 12'hB02, 12'hB82};
    endfunction

    function automatic logic [31:0] m_wview(input logic [11:0] a, input logic [31:0] d);
        case (a)
            12'h300:          return 32'h1800 | (d & 32'h88);
            12'h304:          return d & 32'h80;
            12'h305, 12'h341: return d & ~32'd3;
            default:          return d;
        endcase
    endfunction

    function automatic logic [31:0] m_rdata();
        if (bus.we_i && bus.waddr_i == bus.raddr_i && m_writable(bus.waddr_i))
            return m_wview(bus.waddr_i, bus.wdata_i);
        return m_read(bus.raddr_i);
    endfunction

    task automatic model_step();
        bit          trap, mret, w;
        logic [11:0] wa;
        logic [31:0] wd;
        if (rst) begin
            m_mie = 0; m_mpie = 0; m_mie_reg = 0; m_mip = 0; m_mscratch = 0;
            m_mepc = 0; m_mcause = 0; m_cyc = 0; m_ret = 0;
            m_mtvec = TB_MTVEC_RESET & ~32'd3;
        end else begin
            trap = excepttype != 0 && excepttype[30:0] != 31'ha;
            mret = excepttype == 32'ha;
            w = bus.we_i; wa = bus.waddr_i; wd = bus.wdata_i;
            if (w && wa == 12'hB00) m_cyc[31:0] = wd;
            else if (w && wa == 12'hB80) m_cyc[63:32] = wd;
            else m_cyc = m_cyc + 1;
            if (w && wa == 12'hB02) m_ret[31:0] = wd;
            else if (w && wa == 12'hB82) m_ret[63:32] = wd;
            else if (instret) m_ret = m_ret + 1;
            if (w) begin
                case (wa)
                    12'h300: if (!trap && !mret) begin m_mpie = wd[7]; m_mie = wd[3]; end
                    12'h304: m_mie_reg = m_wview(wa, wd);
                    12'h305: m_mtvec = m_wview(wa, wd);
                    12'h340: m_mscratch = wd;
                    12'h341: if (!trap) m_mepc = m_wview(wa, wd);
                    12'h342: if (!trap) m_mcause = wd;
                    default: ;
                endcase
            end
            if (trap) begin
                m_mepc = pc & ~32'd3; m_mcause = excepttype; m_mpie = m_mie; m_mie = 0;
            end else if (mret) begin
                m_mie = m_mpie; m_mpie = 1;
            end
            m_mip = timer ? 32'h80 : 32'h0;
        end
    endtask

    function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mstatus", mstatus_o, m_mstatus());
            chk("mepc", mepc_o, m_mepc);
            chk("mie", mie_o, m_mie_reg);
            chk("mip", mip_o, m_mip);
            chk("mtvec", mtvec_o, m_mtvec);
            chk("mcause", mcause_o, m_mcause);
            chk("rdata", bus.rdata_o, m_rdata());
            chk("int_pending", {31'b0, int_pending}, {31'b0, m_mie && m_mie_reg[7] && m_mip[7]});
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_in();
        bus.we_i = 0; bus.waddr_i = 0; bus.wdata_i = 0;
        excepttype = 0; pc = 0; instret = 0; timer = 0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        bus.we_i = 1; bus.waddr_i = a; bus.wdata_i = d;
    endtask

    logic [11:0] addrs[14] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                               12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h123, 12'h7C0};

    initial begin
        int r;
        clear_in();
        bus.raddr_i = 12'h301;
        rst = 1;
        tick();
        tick();
        rst = 0;
        chk_en = 1;
        @(negedge clk);
        chk("reset mstatus", mstatus_o, 32'h0000_1800);
        chk("reset mtvec", mtvec_o, 32'h0000_1000);
        chk("reset misa", bus.rdata_o, 32'h4000_0100);
        chk("reset mepc", mepc_o, 32'h0);
        chk("reset int_pending", {31'b0, int_pending}, 32'h0);
        tick();

        wr(12'h305, 32'h8000_0103); bus.raddr_i = 12'h305;
        @(negedge clk);
        chk("bypass mtvec", bus.rdata_o, 32'h8000_0100);
        tick();
        clear_in();
        @(negedge clk);
        chk("mtvec after write", mtvec_o, 32'h8000_0100);
        tick();

        wr(12'h300, 32'h0000_0008);
        tick();
        clear_in(); excepttype = {1'b0, EXC_ECALL}; pc = 32'h40;
        tick();
        clear_in();
        @(negedge clk);
        chk("ecall mepc", mepc_o, 32'h40);
        chk("ecall mcause", mcause_o, 32'hb);
        chk("ecall mstatus", mstatus_o, 32'h1880);
        tick();

        excepttype = {1'b0, EXC_MRET};
        tick();
        clear_in();
        @(negedge clk);
        chk("mret mstatus", mstatus_o, 32'h1888);
        chk("mret mepc", mepc_o, 32'h40);
        tick();

        excepttype = {1'b0, EXC_ILLEGAL}; pc = 32'h80; wr(12'h341, 32'h1234_5678);
        tick();
        clear_in();
        @(negedge clk);
        chk("conflict mepc", mepc_o, 32'h80);
        chk("conflict mcause", mcause_o, 32'h2);
        tick();

        excepttype = {1'b0, EXC_ECALL}; pc = 32'hC0; wr(12'h340, 32'hDEAD_BEEF);
        tick();
        clear_in(); bus.raddr_i = 12'h340;
        @(negedge clk);
        chk("trap+wr mepc", mepc_o, 32'hC0);
        chk("trap+wr mscratch", bus.rdata_o, 32'hDEAD_BEEF);
        tick();

        wr(12'hB00, 32'hFFFF_FFFF);
        tick();
        wr(12'hB80, 32'h0);
        tick();
        clear_in(); bus.raddr_i = 12'hB80;
        tick();
        @(negedge clk);
        chk("mcycle hi carry", bus.rdata_o, 32'h1);
        #1 bus.raddr_i = 12'hB00;
        #1 chk("mcycle lo wrap", bus.rdata_o, 32'h0);
        tick();

        wr(12'h304, 32'hFFFF_FFFF);
        tick();
        wr(12'h300, 32'h8);
        tick();
        clear_in(); timer = 1;
        @(negedge clk);
        chk("mip latency", mip_o, 32'h0);
        chk("int before mip", {31'b0, int_pending}, 32'h0);
        tick();
        @(negedge clk);
        chk("mip set", mip_o, 32'h80);
        chk("mie masked", mie_o, 32'h80);
        chk("int pending", {31'b0, int_pending}, 32'h1);
        tick();

        rst = 1; wr(12'h341, 32'h100); excepttype = {1'b0, EXC_ECALL}; pc = 32'h200;
        instret = 1; timer = 1;
        tick();
        rst = 0; clear_in(); bus.raddr_i = 12'hB00;
        @(negedge clk);
        chk("rst mstatus", mstatus_o, 32'h1800);
        chk("rst mepc", mepc_o, 32'h0);
        chk("rst mcause", mcause_o, 32'h0);
        chk("rst mie", mie_o, 32'h0);
        chk("rst mip", mip_o, 32'h0);
        chk("rst mtvec", mtvec_o, 32'h1000);
        chk("rst mcycle", bus.rdata_o, 32'h0);
        tick();

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(199) == 0);
            bus.we_i = $urandom_range(1);
            bus.waddr_i = addrs[$urandom_range(13)];
            bus.raddr_i = ($urandom_range(3) == 0) ? bus.waddr_i : addrs[$urandom_range(13)];
            bus.wdata_i = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom;
            r = $urandom_range(99);
            if (r < 75)      excepttype = 32'h0;
            else if (r < 82) excepttype = {1'b0, EXC_ILLEGAL};
            else if (r < 88) excepttype = {1'b0, EXC_ECALL};
            else if (r < 94) excepttype = {1'b0, EXC_MRET};
            else if (r < 98) excepttype = 32'h8000_0007;
            else             excepttype = 32'h8000_000a;
            pc = $urandom & ~32'd3;
            instret = $urandom_range(1);
            timer = $urandom_range(1);
            tick();
        end

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
